// File: rtl/mdu.sv
// Iterative RV M-extension multiply/divide, one bit per cycle, valid/ready on both sides.
// Latency XLEN edges (32 in word mode), 1 for divide special cases; result held until ready_i_mdu.
module mdu #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i_mdu,
   output logic            ready_o_mdu,
   input  logic [2:0]      mduop_i_mdu,
   input  logic            word_i_mdu,
   input  logic [XLEN-1:0] op1_i_mdu,
   input  logic [XLEN-1:0] op2_i_mdu,
   input  logic            flush_i_mdu,
   output logic            valid_o_mdu,
   input  logic            ready_i_mdu,
   output logic [XLEN-1:0] result_o_mdu,
   output logic            busy_o_mdu
);

   localparam int CW = (XLEN > 32) ? $clog2(XLEN) : 5;
   localparam int W2 = 2 * XLEN;
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            word_q, word_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [W2-1:0]   a_q, a_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, busy_q;

   function automatic logic [XLEN-1:0] wsext(input logic w, input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = v;
      if (w) begin
         r       = {XLEN{v[31]}};
         r[31:0] = v[31:0];
      end
      return r;
   endfunction

   // Operand preparation for the request currently presented on the inputs
   logic            s1, s2, n1, n2, div_zero, ovf, special;
   logic [XLEN-1:0] x1, x2, m1, m2, min_v, spec_res;
   logic [W2-1:0]   init_a, init_acc;

   always_comb begin
      s1 = (mduop_i_mdu == OP_MULH) || (mduop_i_mdu == OP_MULHSU) ||
           (mduop_i_mdu == OP_DIV)  || (mduop_i_mdu == OP_REM);
      s2 = (mduop_i_mdu == OP_MULH) || (mduop_i_mdu == OP_DIV) || (mduop_i_mdu == OP_REM);
      x1 = op1_i_mdu;
      x2 = op2_i_mdu;
      if (word_i_mdu) begin
         x1       = {XLEN{s1 & op1_i_mdu[31]}};
         x1[31:0] = op1_i_mdu[31:0];
         x2       = {XLEN{s2 & op2_i_mdu[31]}};
         x2[31:0] = op2_i_mdu[31:0];
      end
      n1 = s1 & x1[XLEN-1];
      n2 = s2 & x2[XLEN-1];
      m1 = n1 ? -x1 : x1;
      m2 = n2 ? -x2 : x2;
      min_v = '0;
      min_v[XLEN-1] = 1'b1;
      if (word_i_mdu)
         min_v = {XLEN{1'b1}} << 31;
      div_zero = (x2 == '0);
      ovf      = !mduop_i_mdu[0] && (x1 == min_v) && (x2 == '1);
      special  = mduop_i_mdu[2] && (div_zero || ovf);
      if (div_zero)
         spec_res = mduop_i_mdu[1] ? x1 : '1;
      else
         spec_res = mduop_i_mdu[1] ? '0 : x1;
      init_a   = {{XLEN{1'b0}}, (mduop_i_mdu[2] ? m2 : m1)};
      init_acc = '0;
      if (mduop_i_mdu[2])
         init_acc[XLEN-1:0] = word_i_mdu ? (m1 << (XLEN - 32)) : m1;
   end

   // One iteration step; the accepting edge performs the first one on fresh operands
   logic            cur_dv, ge;
   logic [W2-1:0]   cur_a, cur_acc, nxt_a, nxt_acc, acc_mul;
   logic [XLEN-1:0] cur_b, nxt_b;
   logic [XLEN:0]   rsh, diff;
   logic [XLEN-1:0] rem_n;

   always_comb begin
      if (state_q == IDLE) begin
         cur_dv  = mduop_i_mdu[2];
         cur_a   = init_a;
         cur_b   = m2;
         cur_acc = init_acc;
      end else begin
         cur_dv  = op_q[2];
         cur_a   = a_q;
         cur_b   = b_q;
         cur_acc = acc_q;
      end
      acc_mul = cur_b[0] ? cur_acc + cur_a : cur_acc;
      rsh     = {cur_acc[W2-1:XLEN], cur_acc[XLEN-1]};
      diff    = rsh - {1'b0, cur_a[XLEN-1:0]};
      ge      = (rsh >= {1'b0, cur_a[XLEN-1:0]});
      rem_n   = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
      nxt_b   = cur_b >> 1;
      nxt_a   = cur_dv ? cur_a : (cur_a << 1);
      nxt_acc = cur_dv ? {rem_n, cur_acc[XLEN-2:0], ge} : acc_mul;
   end

   logic [W2-1:0]   prod_s;
   logic [XLEN-1:0] mul_res, div_res, quo, rem, fin;
   logic [CW-1:0]   iter_last;

   always_comb begin
      prod_s  = negq_q ? -nxt_acc : nxt_acc;
      mul_res = ((op_q == OP_MUL) || word_q) ? prod_s[XLEN-1:0] : prod_s[W2-1:XLEN];
      quo     = nxt_acc[XLEN-1:0];
      rem     = nxt_acc[W2-1:XLEN];
      div_res = op_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quo : quo);
      fin     = wsext(word_q, op_q[2] ? div_res : mul_res);
      iter_last = word_q ? CW'(31) : CW'(XLEN - 1);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      word_d   = word_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (valid_i_mdu && !flush_i_mdu) begin
               op_d   = mduop_i_mdu;
               word_d = word_i_mdu;
               negq_d = n1 ^ n2;
               negr_d = n1;
               if (special) begin
                  state_d  = DONE;
                  cnt_d    = '0;
                  result_d = wsext(word_i_mdu, spec_res);
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(1);
                  a_d     = nxt_a;
                  b_d     = nxt_b;
                  acc_d   = nxt_acc;
               end
            end
         end
         CALC: begin
            a_d   = nxt_a;
            b_d   = nxt_b;
            acc_d = nxt_acc;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == iter_last) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = fin;
            end
         end
         DONE: begin
            if (ready_i_mdu)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i_mdu) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         word_q   <= word_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         valid_q  <= (state_d == DONE);
         busy_q   <= (state_d != IDLE);
      end
   end

   assign ready_o_mdu  = (state_q == IDLE);
   assign valid_o_mdu  = valid_q;
   assign busy_o_mdu   = busy_q;
   assign result_o_mdu = result_q;

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized checks of mdu at XLEN = 64 against an arithmetic reference model.
module tb_mdu;
   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            valid_i = 1'b0;
   logic            ready_o;
   logic [2:0]      mduop = '0;
   logic            word = 1'b0;
   logic [XLEN-1:0] op1 = '0;
   logic [XLEN-1:0] op2 = '0;
   logic            flush = 1'b0;
   logic            valid_o;
   logic            ready_i = 1'b1;
   logic [XLEN-1:0] result;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   mdu #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .valid_i_mdu(valid_i), .ready_o_mdu(ready_o),
      .mduop_i_mdu(mduop), .word_i_mdu(word),
      .op1_i_mdu(op1), .op2_i_mdu(op2), .flush_i_mdu(flush),
      .valid_o_mdu(valid_o), .ready_i_mdu(ready_i),
      .result_o_mdu(result), .busy_o_mdu(busy_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic following the ISA definitions
   function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0]       p;
      logic [31:0]        a32, b32, r32;
      logic signed [31:0] sa32, sb32;
      logic signed [63:0] sa, sb;
      logic [63:0]        r;
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32; sa = a; sb = b;
      r32 = '0; r = '0; p = '0;
      if (w) begin
         case (op)
            3'd4: if (b32 == 0) r32 = '1;
                  else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                  else r32 = sa32 / sb32;
            3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
            3'd6: if (b32 == 0) r32 = a32;
                  else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                  else r32 = sa32 % sb32;
            3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
            default: r32 = a32 * b32;
         endcase
         return {{32{r32[31]}}, r32};
      end
      case (op)
         3'd0: r = a * b;
         3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
         3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
         3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
         3'd4: if (b == 0) r = '1;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
               else r = sa / sb;
         3'd5: if (b == 0) r = '1; else r = a / b;
         3'd6: if (b == 0) r = a;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
               else r = sa % sb;
         default: if (b == 0) r = a; else r = a % b;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
      logic zero, over;
      if (w) begin
         zero = (b[31:0] == 0);
         over = !op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1;
      end else begin
         zero = (b == 0);
         over = !op[0] && a == 64'h8000_0000_0000_0000 && b == '1;
      end
      if (op[2] && (zero || over)) return 1;
      return w ? 32 : 64;
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] v;
      case ($urandom_range(0, 6))
         0: v = '0;
         1: v = '1;
         2: v = 64'h8000_0000_0000_0000;
         3: v = {$urandom, 32'h8000_0000};
         4: v = 64'($urandom_range(0, 20));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat,
                      input int hold, input string tag);
      int   guard, lat;
      logic quiet, stable;
      guard = 0;
      while (!ready_o && guard < 300) begin tick(); guard++; end
      mduop = op; word = w; op1 = a; op2 = b; valid_i = 1'b1;
      ready_i = (hold == 0);
      tick();
      valid_i = 1'b0;
      op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
      mduop = 3'($urandom_range(0, 7)); word = 1'($urandom_range(0, 1));
      lat = 1; quiet = 1'b1;
      while (!valid_o && lat < 200) begin
         if (ready_o || !busy_o) quiet = 1'b0;
         tick();
         lat++;
      end
      check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      check({tag, ".res"}, result, exp_res);
      check({tag, ".rdy_low"}, 64'(quiet), 64'd1);
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (!valid_o || ready_o || result !== exp_res) stable = 1'b0;
         end
         check({tag, ".hold"}, 64'(stable), 64'd1);
         ready_i = 1'b1;
      end
      tick();
      check({tag, ".release"}, 64'({valid_o, ready_o}), 64'b01);
   endtask

   initial begin
      logic [2:0]  rop;
      logic        rw;
      logic [63:0] ra, rb;
      logic        seen;

      #2;
      check("reset", 64'({valid_o, ready_o, busy_o}), 64'b010);
      check("reset.res", result, 64'd0);
      valid_i = 1'b1; mduop = 3'd0; op1 = 64'd3; op2 = 64'd4;
      tick();
      check("reset.noaccept", 64'({valid_o, ready_o, busy_o}), 64'b010);
      valid_i = 1'b0;
      rst = 1'b1;
      tick();

      run(3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0, "mul");
      run(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, "mulhu");
      run(3'd1, 1'b0, '1, '1, 64'h0, 64, 0, "mulh");
      run(3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, "mulhsu");
      run(3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "div0");
      run(3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0, "rem0");
      run(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0, "divovf");
      run(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1, 0, "removf");
      run(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 0, "divw");
      run(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 0, "remw");
      run(3'd5, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 32, 0, "divuw");
      run(3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 64, 10, "bp");

      // Flush around iteration 20, then a clean request
      mduop = 3'd4; word = 1'b0; op1 = 64'd100; op2 = 64'd7; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 1; i < 20; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush.state", 64'({valid_o, ready_o, busy_o}), 64'b010);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (valid_o) seen = 1'b1;
         tick();
      end
      check("flush.novalid", 64'(seen), 64'd0);
      run(3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0, "postflush");

      // Asynchronous reset mid-calculation
      mduop = 3'd0; word = 1'b0; op1 = 64'd9; op2 = 64'd9; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b0;
      #1;
      check("arst.ctl", 64'({valid_o, ready_o, busy_o}), 64'b010);
      check("arst.res", result, 64'd0);
      tick();
      rst = 1'b1;
      tick();
      run(3'd5, 1'b0, 64'd1000, 64'd33, 64'd30, 64, 0, "postrst");

      for (int n = 0; n < 48; n++) begin
         rop = 3'($urandom_range(0, 7));
         rw  = 1'($urandom_range(0, 1));
         ra  = pick();
         rb  = pick();
         run(rop, rw, ra, rb, model(rop, rw, ra, rb), model_lat(rop, rw, ra, rb),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             $sformatf("rnd%0d.op%0d.w%0d", n, rop, rw));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit for the execute stage, covering RISC-V M-extension operations, including word-mode (32-bit) variants. It sits beside the single-cycle execute path. Operands come from decode over a valid/ready handshake. It iterates one bit per cycle and holds the result under a second valid/ready handshake until writeback accepts it.

## Interface
- XLEN, 64, datapath width; even, ≥ 8.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- valid_i_mdu  in  1  request valid.
- ready_o_mdu  out  1  unit can accept a request; high exactly when state is IDLE.
- mduop_i_mdu  in  3  operation: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- word_i_mdu  in  1  word mode: operate on low 32 bits, sign-extend the 32-bit result to XLEN.
- op1_i_mdu  in  XLEN  rs1 / dividend.
- op2_i_mdu  in  XLEN  rs2 / divisor.
- flush_i_mdu  in  1  synchronous abort of any in-flight operation.
- valid_o_mdu  out  1  result valid.
- ready_i_mdu  in  1  consumer accepts result.
- result_o_mdu  out  XLEN  result.
- busy_o_mdu  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC: accept when valid_i_mdu & ready_o_mdu & !flush_i_mdu. Latch op, word, operands and sign flags.
- IDLE → DONE directly: accepted division special cases.
  - Divisor zero: div/divu quotient = all ones; rem/remu = dividend.
  - Signed overflow (div/rem with most-negative dividend, divisor −1): quotient = dividend; remainder = 0.
  - In word mode, these checks use the 32-bit views.
- CALC: iteration counter runs ITER cycles. ITER = XLEN, or 32 in word mode. CALC → DONE on the final iteration.
- DONE: valid_o_mdu high. result_o_mdu is held stable while !ready_i_mdu. DONE & ready_i_mdu → IDLE.
- Flush: any state → IDLE on the next edge. The result is discarded and valid_o_mdu drops. Flush has priority over acceptance and over completion.
- Operand width: N = XLEN, or 32 in word mode.
- Signedness:
  - op1 is signed for mulh, mulhsu, div and rem.
  - op2 is signed for mulh, div and rem.
  - Word mode extends the low 32 bits per this signedness.
- Multiply: unsigned shift-add on magnitudes into a 2N-bit product. Negate if the operand signs differ.
  - mul returns the low N bits.
  - mulh* returns the high N bits.
  - word_i_mdu with mulh/mulhsu/mulhu behaves as word mul.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = dividend sign.
- Word-mode results are the low 32 bits sign-extended (including divuw/remuw).
- No same-cycle back-to-back transfer: after a result handshake, ready_o_mdu rises in the following cycle.

## Timing
- Reset (rst low): state IDLE; valid_o_mdu 0; result_o_mdu 0; busy_o_mdu 0; counter 0. ready_o_mdu is 1, but no request is accepted while rst is low.
- Reset asserted mid-operation aborts immediately and asynchronously. No result is produced.
- Latency, counted from the accepting edge to the first cycle with valid_o_mdu high:
  - ITER edges for normal operations (64, or 32 in word mode, at XLEN = 64).
  - 1 edge for division special cases.
- Throughput: one operation per ITER + 2 cycles, given an immediately ready consumer.
- valid_o_mdu, result_o_mdu and busy_o_mdu are registered outputs. ready_o_mdu is decoded from the state register only (no combinational input-to-output path).
- Inputs are sampled only at the accepting edge. They may change freely afterwards.

## Test plan
- mul 7 × −3 (XLEN = 64) → result 0xFFFFFFFFFFFFFFEB. valid_o_mdu high exactly 64 cycles after accept; ready_o_mdu low throughout.
- mulhu with op1 = op2 = 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. mulh with the same operands → 0. mulhsu −1 × 2 → 0xFFFFFFFFFFFFFFFF.
- Special cases:
  - div 5 / 0 → 0xFFFFFFFFFFFFFFFF.
  - rem 5 / 0 → 5.
  - div 0x8000000000000000 / −1 → 0x8000000000000000.
  - rem of the same operands → 0.
  - Each special case has valid_o_mdu high 1 cycle after accept.
- Word mode, op1 = 0x00000000FFFFFFF9, op2 = 2:
  - divw → 0xFFFFFFFFFFFFFFFD.
  - remw → 0xFFFFFFFFFFFFFFFF.
  - divuw → 0x000000007FFFFFFC.
  - Latency 32 cycles.
- Backpressure: hold ready_i_mdu low 10 cycles after valid_o_mdu rises.
  - Result stays constant and ready_o_mdu stays low.
  - On release, valid_o_mdu drops the next cycle and ready_o_mdu rises.
- Aborts:
  - flush_i_mdu at iteration 20 → IDLE next edge; no valid_o_mdu.
  - A new request after the flush completes correctly.
  - Separately, pulse rst low mid-CALC → all outputs return to reset values asynchronously.
